// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for multDiv: launches mult/div, HI/LO writes, and stalls on Busy.
// Optional MD_DIVZERO_SKIP_EN: div/divu with a zero divisor is dropped without launching.
module md_issue_ctrl #(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Valid,
    input  logic [3:0]             MdCls,
    input  logic [31:0]            RsData,
    input  logic [31:0]            RtData,
    input  logic                   Flush,
    input  logic                   Busy,
    output logic                   Start,
    output logic [1:0]             Op,
    output logic [31:0]            D1,
    output logic [31:0]            D2,
    output logic                   We,
    output logic                   HiLo,
    output logic                   Stall,
    output logic [STALL_CNT_W-1:0] StallCnt,
    output logic [1:0]             DbgState
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_e;

    // Handshake: Start/We are single-cycle strobes; multDiv raises Busy from the
    // edge that samples Start, and results are valid once Busy is low in IDLE.
    state_e                 state_q, state_d;
    logic                   wr_pend_q, wr_pend_d;
    logic                   start_q, start_d;
    logic                   we_q, we_d;
    logic [1:0]             op_q, op_d;
    logic [31:0]            d1_q, d1_d;
    logic [31:0]            d2_q, d2_d;
    logic                   hilo_q, hilo_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

    logic is_md, is_muldiv, is_div, is_mt, is_mf;
    logic stall, accept, skip_div, launch, write;
    logic [1:0] op_cls;

    always_comb begin
        is_md     = Valid && (MdCls >= 4'd1) && (MdCls <= 4'd8);
        is_muldiv = (MdCls >= 4'd1) && (MdCls <= 4'd4);
        is_div    = (MdCls == 4'd3) || (MdCls == 4'd4);
        is_mt     = (MdCls == 4'd7) || (MdCls == 4'd8);
        is_mf     = (MdCls == 4'd5) || (MdCls == 4'd6);

        stall  = is_md && ((state_q != S_IDLE) || Busy || wr_pend_q);
        accept = is_md && !stall && !Flush;

`ifdef MD_DIVZERO_SKIP_EN
        skip_div = is_div && (RtData == 32'd0);
`else
        skip_div = 1'b0;
`endif

        launch = accept && is_muldiv && !skip_div;
        write  = accept && is_mt;

        case (MdCls)
            4'd1:    op_cls = 2'b01;
            4'd2:    op_cls = 2'b00;
            4'd3:    op_cls = 2'b11;
            4'd4:    op_cls = 2'b10;
            default: op_cls = 2'b00;
        endcase

        state_d = state_q;
        case (state_q)
            S_IDLE:   if (launch) state_d = S_LAUNCH;
            // Busy from the unit only appears after the Start edge.
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT:   if (!Busy) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        start_d   = launch;
        we_d      = write;
        wr_pend_d = write;
        op_d      = launch ? op_cls : op_q;
        d1_d      = (launch || write) ? RsData : d1_q;
        d2_d      = launch ? RtData : d2_q;
        hilo_d    = write ? (MdCls == 4'd7) : hilo_q;
        cnt_d     = (stall && (cnt_q != {STALL_CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            wr_pend_q <= 1'b0;
            start_q   <= 1'b0;
            we_q      <= 1'b0;
            op_q      <= 2'b00;
            d1_q      <= 32'd0;
            d2_q      <= 32'd0;
            hilo_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_pend_q <= wr_pend_d;
            start_q   <= start_d;
            we_q      <= we_d;
            op_q      <= op_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            hilo_q    <= hilo_d;
            cnt_q     <= cnt_d;
        end
    end

    // An mf in E steers the read port directly; otherwise the last write target holds.
    assign HiLo     = (Valid && is_mf) ? (MdCls == 4'd5) : hilo_q;
    assign Start    = start_q;
    assign We       = we_q;
    assign Op       = op_q;
    assign D1       = d1_q;
    assign D2       = d2_q;
    assign Stall    = stall;
    assign StallCnt = cnt_q;
    assign DbgState = state_q;

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Execute-stage initiator for the multiply/divide unit (`multDiv`). Decodes the E-stage instruction class, launches operations and HI/LO writes onto the unit's Start/Op/We/HiLo interface through registered outputs, and tracks the unit's Busy so that later mult/div/mf/mt instructions stall the pipeline until results are valid. Sits between the E-stage decode/bypass logic and `multDiv`; HI/LO read data flows from the unit straight to the E-stage result mux.

## Interface
- `STALL_CNT_W`, 32: width of the stall-cycle counter.
- `Clk` in 1: clock, rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `Valid` in 1: E-stage holds a live instruction.
- `MdCls` in 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9–15 treated as none.
- `RsData` in 32: forwarded rs value.
- `RtData` in 32: forwarded rt value.
- `Flush` in 1: kill the E-stage instruction this cycle.
- `Busy` in 1: from `multDiv`.
- `Start` out 1: one-cycle launch pulse to `multDiv`.
- `Op` out 2: 00 multu, 01 mult, 10 divu, 11 div.
- `D1` out 32, `D2` out 32: operands (rs, rt).
- `We` out 1: HI/LO write strobe (mthi/mtlo); write data on `D1`.
- `HiLo` out 1: 1 = HI, 0 = LO; selects the write target and the read port for mf.
- `Stall` out 1: freeze F/D/E this cycle (combinational).
- `StallCnt` out STALL_CNT_W: cycles with `Stall`=1, saturating.

## Operation
- Accept: `Valid` & `MdCls` in 1–8 & !`Stall` & !`Flush`. Only accepted instructions drive the unit.
- On accepting mult/div (classes 1–4): the next cycle, `Start`=1 and `Op`/`D1`/`D2` are registered from the class and `RsData`/`RtData`.
- On accepting mthi/mtlo (classes 7–8): the next cycle, `We`=1, `HiLo` is set, and `D1`=`RsData`.
- mfhi/mflo: `HiLo` is driven combinationally from the class while in E (1 for mfhi). There is no pulse to the unit.
- `Start`/`We` are single-cycle pulses. `Op`/`D1`/`D2`/`HiLo` hold their values until the next accept.
- FSM:
  - IDLE: on accepting classes 1–4, go to LAUNCH.
  - LAUNCH: `Start` is high. Always go to WAIT; the unit's Busy is not visible until this cycle's edge.
  - WAIT: go to IDLE when `Busy`=0; otherwise stay.
  - mt writes do not leave IDLE. A one-cycle `WrPend` flag covers the `We` cycle.
- Stall = `Valid` & `MdCls` in 1–8 & (state != IDLE | `Busy` | `WrPend`).
  - `Flush` does not mask `Stall`.
  - Non-md instructions never stall.
- `Flush` during LAUNCH/WAIT does not abort the unit: the operation completes and the FSM follows `Busy`.
- `StallCnt` increments each cycle `Stall`=1 and saturates at all-ones.

## Timing
- Reset values:
  - FSM and `WrPend`: IDLE, 0.
  - `Start`, `We`, `Op`, `D1`, `D2`: 0.
  - `StallCnt`: 0.
  - `HiLo` register: 0.
- Issue latency: instruction accepted at edge N; `Start` is high during cycle N+1.
- The earliest a dependent md-class instruction can be accepted is the first cycle with state IDLE and `Busy`=0.
- mtlo followed immediately by mflo: the mflo stalls exactly 1 cycle.
- `Rst` mid-operation: state returns to IDLE and no `Start` is emitted. `multDiv` shares `Rst`.
- Accept and `Flush` in the same cycle: `Flush` wins; no `Start`/`We`.

## Configuration
- `MD_DIVZERO_SKIP_EN`
  - Defined: an accepted div/divu with `RtData`==0 issues no `Start`, stays in IDLE, and leaves HI/LO unchanged.
  - Undefined: it launches normally, and the HI/LO result is whatever `multDiv` produces.

## Test plan
- Reset held for 2 cycles → all outputs 0, `Stall`=0, state IDLE.
- div with rs=32'hffffff41, rt=32'h25 → `Start`=1 for exactly one cycle, `Op`=11, `D1`/`D2` equal to the operands. A following mflo stalls until 1 cycle after `Busy` falls, and `StallCnt` equals those stall cycles.
- mthi 32'h1234 then mfhi back-to-back → `We`=1 with `HiLo`=1 for one cycle; mfhi stalls 1 cycle.
- mult accepted with `Flush`=1 → no `Start`, state stays IDLE, `Stall`=0.
- divu with rt=0 → macro defined: no `Start`, no stall on a following mflo. Macro undefined: `Start` issues.
- `Rst` asserted during WAIT → next cycle state IDLE; a pending mflo is accepted with `Stall`=0 once `Busy`=0.
